// File: rtl/spwm_channel_if.sv
// Handshake and gate bundle between the sequencing FSM and one SPWM carrier channel.
interface spwm_channel_if #(
  parameter int DW = 10
);
  logic          ePWMs;
  logic          rst_syn;
  logic [DW-1:0] duty;
  logic          rdy;
  logic          pwm_h;
  logic          pwm_l;

  modport master (output ePWMs, rst_syn, duty, input rdy, pwm_h, pwm_l);
  modport slave  (input ePWMs, rst_syn, duty, output rdy, pwm_h, pwm_l);
endinterface

// File: rtl/spwm_channel.sv
// One SPWM carrier channel: carrier counter, duty latch with clamp,
// trailing-edge compare, and a dead-time gate FSM driving a complementary pair.
module spwm_channel #(
  parameter int CW       = 10,
  parameter int PERIOD   = 1000,
  parameter int DW       = 10,
  parameter int LOAD_CNT = 4,
  parameter int DEAD     = 8
) (
  input  logic          clk,
  input  logic          rst,
  spwm_channel_if.slave bus
);

  // Wide enough for both the duty word and the CW+1 bit carrier compare.
  localparam int XW = ((DW > CW) ? DW : CW) + 1;
  localparam logic [XW-1:0] DMAX = XW'(PERIOD - LOAD_CNT - 1);

  typedef enum logic [1:0] {OFF, DT, HI, LO} st_t;

  logic          running;
  logic [CW-1:0] cnt;
  logic [CW-1:0] duty_l;
  logic          wrap;
  logic [XW-1:0] duty_x;
  logic [XW-1:0] duty_c;
  logic [CW:0]   thr;
  logic          cmp;

  st_t           st, st_n;
  logic          tgt, tgt_n;
  logic [7:0]    dcnt, dcnt_n;
  logic          pwm_h_q, pwm_l_q;
  logic          pwm_h_n, pwm_l_n;

  assign running = bus.ePWMs & ~bus.rst_syn;
  assign wrap    = (cnt == CW'(PERIOD - 1));

  // rdy decodes the registered counter, so it cannot glitch.
  assign bus.rdy = running & wrap;

  // Clamp keeps cmp low through cnt==LOAD_CNT, so reloading duty_l never glitches the gate.
  assign duty_x = XW'(bus.duty);
  assign duty_c = (duty_x > DMAX) ? DMAX : duty_x;

  // Trailing-edge aligned: the on-time sits at the end of the period.
  assign thr = (CW+1)'(PERIOD) - {1'b0, duty_l};
  assign cmp = running & ({1'b0, cnt} >= thr);

  // Carrier counter: free-runs while enabled, held at 0 otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (!running) cnt <= '0;
    else if (wrap)     cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  // Duty latch: sample once per period at cnt==LOAD_CNT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            duty_l <= '0;
    else if (!running)                   duty_l <= '0;
    else if (cnt == CW'(LOAD_CNT))       duty_l <= duty_c[CW-1:0];
  end

  // Gate FSM state register; gate outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= OFF;
      tgt     <= 1'b0;
      dcnt    <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      st      <= st_n;
      tgt     <= tgt_n;
      dcnt    <= dcnt_n;
      pwm_h_q <= pwm_h_n;
      pwm_l_q <= pwm_l_n;
    end
  end

  // Gate FSM next state: every cmp change passes through DEAD cycles of both-low.
  always_comb begin
    st_n   = st;
    tgt_n  = tgt;
    dcnt_n = dcnt;
    if (!running) begin
      st_n   = OFF;
      tgt_n  = 1'b0;
      dcnt_n = '0;
    end else begin
      case (st)
        OFF: begin
          st_n   = DT;
          tgt_n  = cmp;
          dcnt_n = '0;
        end
        DT: begin
          if (cmp != tgt) begin
            tgt_n  = cmp;
            dcnt_n = '0;
          end else if (dcnt == 8'(DEAD - 1)) begin
            st_n = tgt ? HI : LO;
          end else begin
            dcnt_n = dcnt + 8'd1;
          end
        end
        HI: begin
          if (!cmp) begin
            st_n   = DT;
            tgt_n  = 1'b0;
            dcnt_n = '0;
          end
        end
        LO: begin
          if (cmp) begin
            st_n   = DT;
            tgt_n  = 1'b1;
            dcnt_n = '0;
          end
        end
        default: st_n = OFF;
      endcase
    end
  end

  // Gate FSM outputs: one gate per conducting state, never both.
  always_comb begin
    pwm_h_n = (st_n == HI);
    pwm_l_n = (st_n == LO);
  end

  assign bus.pwm_h = pwm_h_q;
  assign bus.pwm_l = pwm_l_q;

endmodule

// File: doc/spwm_channel.md
# spwm_channel

One SPWM carrier channel that answers the sequencing FSM's handshake: it runs a carrier counter, compares it against a sine-table duty word, drives a complementary high/low gate pair with dead time, and pulses `rdy` once per carrier period so the FSM can advance the sample index. Two instances are used, one for the positive half-cycle (`rdyP`, `rst_synP`) and one for the negative half-cycle (`rdyN`, `rst_synN`). Both are driven by the FSM's `ePWMs`, and the duty word comes from the quarter-wave LUT addressed by the up/down counter.

## Interface
- `CW`, 10: carrier counter width; `PERIOD <= 2^CW`.
- `PERIOD`, 1000: carrier period in clk cycles, at least `LOAD_CNT+2`.
- `DW`, 10: duty word width.
- `LOAD_CNT`, 4: carrier count at which `duty` is sampled.
- `DEAD`, 8: dead-time in clk cycles, at least 1. `dcnt` is 8 bits wide.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ePWMs` in 1: global PWM enable from the FSM.
- `rst_syn` in 1: synchronous channel hold, active-high; comes from the FSM's `rst_synP`/`rst_synN`.
- `duty` in DW: high-side on-time in clk cycles, from the LUT.
- `rdy` out 1: one-cycle end-of-period strobe.
- `pwm_h` out 1: high-side gate, registered.
- `pwm_l` out 1: low-side gate, registered.

## Operation
**Enable**
- `running = ePWMs & ~rst_syn`.
- When `running` is 0, the next state is: `cnt=0`, `duty_l=0`, gate FSM in OFF, `dcnt=0`. Both gates go low on the next edge.
- Reset (`rst=0`) forces the same values immediately. At reset every output is 0.

**Carrier counter**
- While running, `cnt` increments each cycle and wraps from `PERIOD-1` to 0.
- The first running cycle has `cnt=0`.

**rdy**
- `rdy = running & (cnt == PERIOD-1)`. It is decoded from the registered `cnt`, so it is glitch-free.
- It is high exactly one cycle per period.
- The FSM samples `rdy` on the same edge that wraps `cnt`.

**Duty latch**
- On the edge ending the cycle with `cnt == LOAD_CNT`: `duty_l <= min(duty, PERIOD-LOAD_CNT-1)`.
- The comparison is done in CW+1 bits.
- The clamp guarantees `cmp = 0` for all `cnt <= LOAD_CNT`, so the duty update never glitches the output.

**Compare**
- `cmp = running & (cnt >= PERIOD - duty_l)`, combinational.
- This gives trailing-edge-aligned pulses.

**Gate FSM**
- States: OFF, DT, HI, LO, plus a target bit `tgt` and counter `dcnt`.
- Outputs: `pwm_h = (st==HI)`, `pwm_l = (st==LO)`. Never both high.
- OFF & running → DT, with `tgt<=cmp`, `dcnt<=0`.
- In DT:
  - If `cmp != tgt`: `tgt<=cmp`, `dcnt<=0`.
  - Else if `dcnt == DEAD-1`: go to HI if `tgt`, else LO.
  - Else `dcnt++`.
- HI & ~cmp → DT, with `tgt<=0`, `dcnt<=0`.
- LO & cmp → DT, with `tgt<=1`, `dcnt<=0`.
- Not running → OFF from any state. This has priority over all other transitions.

## Timing
- If `cmp` changes in cycle t, the old gate is low from cycle t+1.
- The new gate is high from cycle t+DEAD+1, provided `cmp` is stable through t+DEAD.
- A `cmp` pulse shorter than DEAD+1 cycles never reaches a gate; both gates stay low and dead time restarts.
- After `rst_syn` falls, `pwm_l` rises at running cycle DEAD+1 (`cnt=DEAD+1`) when `duty=0`.
- `rst_syn` or `ePWMs` asserted mid-period: both gates and `rdy` are 0 from the next edge, and `cnt` restarts at 0 on re-enable. A partial period produces no `rdy`.
- A `duty` change takes effect only in the period following the next `cnt==LOAD_CNT` sample.

## Test plan
Parameters for all scenarios: `PERIOD=20`, `LOAD_CNT=4`, `DEAD=2`.

1. **Reset:** `rst=0` mid-run → `rdy`, `pwm_h`, `pwm_l` are 0 immediately. After release with `rst_syn=1` they stay 0.
2. **Basic run:** `ePWMs=1`, `rst_syn` 1→0, `duty=5` →
   - `pwm_l` high at `cnt` 3..15.
   - `pwm_h` high at `cnt` 18, 19, and the next period's `cnt` 0.
   - Both low at `cnt` 16, 17, 1, 2.
   - `rdy` high only at `cnt=19`, one pulse per 20 cycles.
3. **Clamp:** `duty=100` → `duty_l=15`, `pwm_h` high at `cnt` 8..19 and 0, `pwm_l` high at `cnt` 3..5.
4. **Narrow pulse:** `duty=1` → `pwm_h` never high, `pwm_l` low at `cnt` 0..2 each period. `duty=0` → `pwm_h` always low.
5. **Mid-period hold:** `rst_syn` pulsed high at `cnt=10` → gates low the next cycle, no `rdy` for that period. After release, `cnt` restarts at 0 and the first `rdy` comes 20 cycles later.
6. **Duty change:** `duty` changed 5→8 at `cnt=7` → current period unchanged. The next period has `pwm_h` rising at `cnt=15`.
